// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - 2-entry in-order writeback FIFO with register-file drain and decode forwarding
module writeback_queue #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [2:0]        in_write_reg,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic              rf_stall,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [2:0]        read_reg_1,
  input  logic [2:0]        read_reg_2,
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2,
  output logic [1:0]        pending
);
  localparam int DEPTH = 2;

  logic [DEPTH-1:0]  q_rw;
  logic [2:0]        q_reg  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;
  logic              not_empty;
  logic              full;

  assign not_empty = (count != 2'd0);
  assign full      = (count == 2'd2);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign pop       = not_empty && !rf_stall;
  assign pending   = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_rw   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        q_reg[i]  <= 3'd0;
        q_data[i] <= '0;
      end
    end else begin
      if (push) begin
        q_rw[wr_ptr]   <= in_reg_write;
        q_reg[wr_ptr]  <= in_write_reg;
        q_data[wr_ptr] <= in_write_data;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head drives the write port; an empty queue presents zeros.
  always_comb begin
    rf_waddr = 3'd0;
    rf_wdata = '0;
    rf_we    = 1'b0;
    if (not_empty) begin
      rf_waddr = q_reg[rd_ptr];
      rf_wdata = q_data[rd_ptr];
      rf_we    = !rf_stall && q_rw[rd_ptr] && (q_reg[rd_ptr] != 3'd0);
    end
  end

  logic [2:0]        rr       [2];
  logic              hit      [2];
  logic [DATA_W-1:0] hit_data [2];
  logic              young;

  assign rr[0] = read_reg_1;
  assign rr[1] = read_reg_2;
  assign young = ~rd_ptr;

  // Older (head) entry first so a matching younger entry overrides it.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      hit[k]      = 1'b0;
      hit_data[k] = '0;
      if (rr[k] != 3'd0) begin
        if (not_empty && q_rw[rd_ptr] && (q_reg[rd_ptr] == rr[k])) begin
          hit[k]      = 1'b1;
          hit_data[k] = q_data[rd_ptr];
        end
        if (full && q_rw[young] && (q_reg[young] == rr[k])) begin
          hit[k]      = 1'b1;
          hit_data[k] = q_data[young];
        end
      end
    end
  end

  assign fwd_hit_1  = hit[0];
  assign fwd_hit_2  = hit[1];
  assign fwd_data_1 = hit_data[0];
  assign fwd_data_2 = hit_data[1];
endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue with a queue-based reference model
module tb_writeback_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_reg_write = 1'b0;
  logic [2:0]  in_write_reg = 3'd0;
  logic [15:0] in_write_data = 16'd0;
  logic        rf_stall = 1'b0;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [2:0]  read_reg_1 = 3'd0;
  logic [2:0]  read_reg_2 = 3'd0;
  logic        fwd_hit_1, fwd_hit_2;
  logic [15:0] fwd_data_1, fwd_data_2;
  logic [1:0]  pending;

  writeback_queue #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_write_reg(in_write_reg), .in_write_data(in_write_data),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
    .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [2:0]  wreg;
    logic [15:0] data;
  } ent_t;

  ent_t mq[$];
  ent_t expq[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: queue ops on accepted entries, youngest-first search for forwarding.
  function automatic logic [16:0] model_fwd(input logic [2:0] rr);
    if (rr == 3'd0) return 17'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].rw && mq[i].wreg == rr) return {1'b1, mq[i].data};
    return 17'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      expq.delete();
    end else begin
      logic do_push, do_pop;
      ent_t e;
      do_push = in_valid && (mq.size() < 2);
      do_pop  = (mq.size() > 0) && !rf_stall;
      e.rw = in_reg_write; e.wreg = in_write_reg; e.data = in_write_data;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(e);
        if (e.rw && e.wreg != 3'd0) expq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    logic        exp_we;
    logic [16:0] f1, f2;
    ent_t        w;
    exp_we = (mq.size() > 0) && !rf_stall && mq[0].rw && (mq[0].wreg != 3'd0);
    chk("rf_we", rf_we, exp_we);
    chk("pending", pending, mq.size());
    chk("in_ready", in_ready, mq.size() < 2);
    chk("rf_waddr", rf_waddr, (mq.size() > 0) ? mq[0].wreg : 3'd0);
    chk("rf_wdata", rf_wdata, (mq.size() > 0) ? mq[0].data : 16'd0);
    f1 = model_fwd(read_reg_1);
    f2 = model_fwd(read_reg_2);
    chk("fwd_1", {fwd_hit_1, fwd_data_1}, f1);
    chk("fwd_2", {fwd_hit_2, fwd_data_2}, f2);
    if (rf_we) begin
      if (expq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        w = expq.pop_front();
        chk("sb_waddr", rf_waddr, w.wreg);
        chk("sb_wdata", rf_wdata, w.data);
      end
    end
  end

  task automatic cyc(input logic v, input logic rw, input logic [2:0] wr, input logic [15:0] d,
                     input logic st, input logic [2:0] r1, input logic [2:0] r2);
    in_valid = v; in_reg_write = rw; in_write_reg = wr; in_write_data = d;
    rf_stall = st; read_reg_1 = r1; read_reg_2 = r2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_pending", pending, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_we", rf_we, 0);
    chk("reset_fwd", {fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Single write
    cyc(1, 1, 3, 16'h00A5, 0, 3, 0);
    chk("single_we", rf_we, 1);
    chk("single_addr", rf_waddr, 3);
    chk("single_data", rf_wdata, 16'h00A5);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("single_drain", pending, 0);

    // Stall fill then release
    cyc(1, 1, 1, 16'h1111, 1, 0, 0);
    cyc(1, 1, 2, 16'h2222, 1, 0, 0);
    chk("fill_pending", pending, 2);
    chk("fill_ready", in_ready, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("hold_pending", pending, 2);
    chk("hold_head", rf_waddr, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("fill_drained", pending, 0);

    // Youngest forward
    cyc(1, 1, 5, 16'h0001, 1, 5, 0);
    chk("fwd_head", {fwd_hit_1, fwd_data_1}, {1'b1, 16'h0001});
    cyc(1, 1, 5, 16'h0002, 1, 5, 0);
    chk("fwd_young_hit", fwd_hit_1, 1);
    chk("fwd_young_data", fwd_data_1, 16'h0002);
    cyc(0, 0, 0, 0, 0, 5, 0);
    cyc(0, 0, 0, 0, 0, 5, 0);

    // r0 suppression
    cyc(1, 1, 0, 16'hFFFF, 0, 0, 0);
    chk("r0_we", rf_we, 0);
    chk("r0_pending", pending, 1);
    chk("r0_fwd2", fwd_hit_2, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("r0_drained", pending, 0);

    // Streaming
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 3'(i % 7 + 1), 16'(16'h100 + i), 0, 0, 0);
      chk("stream_ready", in_ready, 1);
      chk("stream_pending", pending, 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-run
    cyc(1, 1, 4, 16'h4444, 1, 4, 0);
    cyc(1, 1, 6, 16'h6666, 1, 4, 6);
    rf_stall = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_pending", pending, 0);
    chk("midrst_we", rf_we, 0);
    chk("midrst_fwd", fwd_hit_1, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 4, 6);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
          16'($urandom), ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("sb_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
